// File: rtl/prefix_adder_pkg.sv
// prefix_adder_pkg
//   Shared constants and helpers for the prefix-adder arbiter slice.
//   ADD_W      : fixed operand width of the shared prefix adder.
//   MAX_REQ    : largest supported requester count.
//   clog2_min1 : ceil(log2(n)), never less than 1 (ID width helper).
//   rr_pick    : round-robin search, first set bit at or after ptr with wrap.
package prefix_adder_pkg;

    localparam int ADD_W   = 8;
    localparam int MAX_REQ = 16;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Scans n positions starting at ptr; index wraps back to 0 past n-1.
    // Returns 0 when nothing is valid (caller gates the grant separately).
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                   input int                 ptr,
                                   input int                 n);
        int   idx;
        int   pick;
        logic found;
        pick  = 0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && valid[idx[3:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/prefix_adder8.sv
// prefix_adder8
//   Combinational 8-bit parallel-prefix (Kogge-Stone style) adder.
//   a, b : 8-bit unsigned operands.
//   sum  : 9-bit result, carry-out in the MSB. Carry-in is tied to 0.
module prefix_adder8
    import prefix_adder_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    output logic [ADD_W:0]   sum
);

    // Level k holds group generate/propagate over a span of 2^k bits
    // ending at bit i. After level 3, g3[i] is the generate of [i:0].
    logic [ADD_W-1:0] g0, p0;
    logic [ADD_W-1:0] g1, p1;
    logic [ADD_W-1:0] g2, p2;
    logic [ADD_W-1:0] g3;
    logic [ADD_W-1:0] carry;

    always_comb begin
        g0 = a & b;
        p0 = a ^ b;

        g1 = g0;
        p1 = p0;
        for (int i = 1; i < ADD_W; i++) begin
            g1[i] = g0[i] | (p0[i] & g0[i-1]);
            p1[i] = p0[i] & p0[i-1];
        end

        g2 = g1;
        p2 = p1;
        for (int i = 2; i < ADD_W; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[i-2]);
            p2[i] = p1[i] & p1[i-2];
        end

        g3 = g2;
        for (int i = 4; i < ADD_W; i++) begin
            g3[i] = g2[i] | (p2[i] & g2[i-4]);
        end

        // Carry into bit i is the group generate of [i-1:0]; bit 0 sees cin=0.
        carry[0] = 1'b0;
        for (int i = 1; i < ADD_W; i++) begin
            carry[i] = g3[i-1];
        end

        sum = {g3[ADD_W-1], p0 ^ carry};
    end

endmodule

// File: rtl/prefix_adder_arbiter.sv
// prefix_adder_arbiter
//   Round-robin arbiter sharing one prefix_adder8 among N_REQ requesters,
//   with a one-entry registered result stage.
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset.
//   req_valid/ready  : per-requester handshake; req_ready is one-hot or zero.
//   req_a, req_b     : packed operands, requester i at [i*WIDTH +: WIDTH].
//   rsp_valid/ready  : result handshake.
//   rsp_sum, rsp_id  : registered WIDTH+1-bit sum and winning requester index.
//   busy             : result pending or any request present.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A requester holds valid and operands until ready; the result stage
// holds rsp_sum/rsp_id stable while rsp_valid=1 and rsp_ready=0. The stage is
// free when empty or being drained this cycle, so one result per cycle flows.
module prefix_adder_arbiter
    import prefix_adder_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = clog2_min1(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH:0]         rsp_sum,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
);

    if (WIDTH != ADD_W) begin : g_bad_width
        $error("prefix_adder_arbiter: WIDTH must equal 8");
    end
    if (N_REQ < 1 || N_REQ > MAX_REQ) begin : g_bad_nreq
        $error("prefix_adder_arbiter: N_REQ must be 1..16");
    end

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    next_ptr;
    logic [MAX_REQ-1:0] valid_pad;
    logic               slot_free;
    logic               grant;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH:0]     add_sum;

    assign slot_free = !rsp_valid || rsp_ready;
    // rst_n in the grant term keeps req_ready low while reset is asserted,
    // even though the comb path would otherwise see valid requests.
    assign grant     = rst_n && slot_free && (|req_valid);
    assign busy      = rsp_valid || (|req_valid);

    always_comb begin
        valid_pad = '0;
        for (int i = 0; i < N_REQ; i++) begin
            valid_pad[i] = req_valid[i];
        end
        gnt_idx = ID_W'(rr_pick(valid_pad, int'(rr_ptr), N_REQ));
    end

    always_comb begin
        req_ready = '0;
        op_a      = '0;
        op_b      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                req_ready[i] = grant;
                op_a         = req_a[i*WIDTH +: WIDTH];
                op_b         = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign next_ptr = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;

    prefix_adder8 u_adder (
        .a   (op_a),
        .b   (op_b),
        .sum (add_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= add_sum;
            rsp_id    <= gnt_idx;
            rr_ptr    <= next_ptr;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prefix_adder_arbiter.sv
// tb_prefix_adder_arbiter
//   Directed bench for prefix_adder_arbiter (N_REQ=4, WIDTH=8). Inputs are
//   driven on the falling edge; outputs are sampled 1 ns later.
module tb_prefix_adder_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH:0]         rsp_sum;
    logic [ID_W-1:0]        rsp_id;
    logic                   busy;

    int tests = 0;
    int fails = 0;

    // Round-robin operand set and hand-computed sums.
    logic [7:0] rr_a   [4] = '{8'h11, 8'h80, 8'hC3, 8'hFE};
    logic [7:0] rr_b   [4] = '{8'h22, 8'h90, 8'h3D, 8'h03};
    logic [8:0] rr_sum [4] = '{9'h033, 9'h110, 9'h100, 9'h101};

    always #5 clk = ~clk;

    prefix_adder_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    task automatic set_pair(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    task automatic load_rr_pairs();
        for (int i = 0; i < 4; i++) begin
            set_pair(i, rr_a[i], rr_b[i]);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_a     = 32'h0102_0304;
        req_b     = 32'h0506_0708;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", rsp_valid); end
        tests++; if (rsp_sum !== 9'h000) begin fails++; $display("FAIL reset_sum: got %h exp 000", rsp_sum); end
        tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_id: got %0d exp 0", rsp_id); end
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy_req: got %b exp 1", busy); end
        @(negedge clk);
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b exp 0", busy); end
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL idle_ready: got %b exp 0000", req_ready); end
    endtask

    task automatic test_single();
        @(negedge clk);
        set_pair(2, 8'h5A, 8'h3C);
        req_valid = 4'b0100;
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b exp 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b exp 1", rsp_valid); end
        tests++; if (rsp_sum !== 9'h096) begin fails++; $display("FAIL single_sum: got %h exp 096", rsp_sum); end
        tests++; if (rsp_id !== 2'd2) begin fails++; $display("FAIL single_id: got %0d exp 2", rsp_id); end
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL single_ready_drop: got %b exp 0000", req_ready); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b exp 1", busy); end
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_drain: got %b exp 0", rsp_valid); end
    endtask

    task automatic test_carry();
        int         idx [3] = '{0, 1, 3};
        logic [7:0] ca  [3] = '{8'hFF, 8'hFF, 8'h00};
        logic [7:0] cb  [3] = '{8'h01, 8'hFF, 8'h00};
        logic [8:0] cs  [3] = '{9'h100, 9'h1FE, 9'h000};
        logic [3:0] oh;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_pair(idx[k], ca[k], cb[k]);
            oh = 4'b0001 << idx[k];
            req_valid = oh;
            #1;
            tests++; if (req_ready !== oh) begin fails++; $display("FAIL carry_ready[%0d]: got %b exp %b", k, req_ready, oh); end
            @(negedge clk);
            req_valid = 4'b0000;
            #1;
            tests++; if (rsp_sum !== cs[k]) begin fails++; $display("FAIL carry_sum[%0d]: got %h exp %h", k, rsp_sum, cs[k]); end
            tests++; if (rsp_id !== ID_W'(idx[k])) begin fails++; $display("FAIL carry_id[%0d]: got %0d exp %0d", k, rsp_id, idx[k]); end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int         i;
        logic [7:0] a, b;
        logic [8:0] exp_sum;
        logic [3:0] oh;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            i       = $urandom_range(0, 3);
            a       = 8'($urandom_range(0, 255));
            b       = 8'($urandom_range(0, 255));
            exp_sum = {1'b0, a} + {1'b0, b};
            set_pair(i, a, b);
            oh = 4'b0001 << i;
            req_valid = oh;
            #1;
            tests++; if (req_ready !== oh) begin fails++; $display("FAIL rand_ready[%0d]: got %b exp %b", k, req_ready, oh); end
            @(negedge clk);
            req_valid = 4'b0000;
            #1;
            tests++; if (rsp_sum !== exp_sum) begin fails++; $display("FAIL rand_sum[%0d]: a=%h b=%h got %h exp %h", k, a, b, rsp_sum, exp_sum); end
            tests++; if (rsp_id !== ID_W'(i)) begin fails++; $display("FAIL rand_id[%0d]: got %0d exp %0d", k, rsp_id, i); end
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int         prev;
        logic [3:0] oh;
        load_rr_pairs();
        // Grant requester 3 alone so the pointer lands on 0.
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL rr_prime: got %b exp 1000", req_ready); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            prev = (k == 0) ? 3 : (k - 1) % 4;
            oh   = 4'b0001 << (k % 4);
            #1;
            tests++; if (req_ready !== oh) begin fails++; $display("FAIL rr_grant[%0d]: got %b exp %b", k, req_ready, oh); end
            tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL rr_nobubble[%0d]: got %b exp 1", k, rsp_valid); end
            tests++; if (rsp_id !== ID_W'(prev)) begin fails++; $display("FAIL rr_id[%0d]: got %0d exp %0d", k, rsp_id, prev); end
            tests++; if (rsp_sum !== rr_sum[prev]) begin fails++; $display("FAIL rr_sum[%0d]: got %h exp %h", k, rsp_sum, rr_sum[prev]); end
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        tests++; if (rsp_id !== 2'd1) begin fails++; $display("FAIL rr_last_id: got %0d exp 1", rsp_id); end
        tests++; if (rsp_sum !== 9'h110) begin fails++; $display("FAIL rr_last_sum: got %h exp 110", rsp_sum); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        // Pointer is 2 after the round-robin run.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL bp_first: got %b exp 0100", req_ready); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d]: got %b exp 0000", k, req_ready); end
            tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b exp 1", k, rsp_valid); end
            tests++; if (rsp_id !== 2'd2) begin fails++; $display("FAIL bp_id[%0d]: got %0d exp 2", k, rsp_id); end
            tests++; if (rsp_sum !== 9'h100) begin fails++; $display("FAIL bp_sum[%0d]: got %h exp 100", k, rsp_sum); end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL bp_release_grant: got %b exp 1000", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_swap_valid: got %b exp 1", rsp_valid); end
        tests++; if (rsp_id !== 2'd3) begin fails++; $display("FAIL bp_swap_id: got %0d exp 3", rsp_id); end
        tests++; if (rsp_sum !== 9'h101) begin fails++; $display("FAIL bp_swap_sum: got %h exp 101", rsp_sum); end
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b exp 0", rsp_valid); end
    endtask

    task automatic test_pointer_wrap();
        // Pointer is 0; granting 2 moves it to 3.
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL wrap_set: got %b exp 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL wrap_sparse: got %b exp 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b1010;
        #1;
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL wrap_3_first: got %b exp 1000", req_ready); end
        tests++; if (rsp_id !== 2'd1) begin fails++; $display("FAIL wrap_id1: got %0d exp 1", rsp_id); end
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL wrap_1_next: got %b exp 0010", req_ready); end
        tests++; if (rsp_id !== 2'd3) begin fails++; $display("FAIL wrap_id3: got %0d exp 3", rsp_id); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        tests++; if (rsp_id !== 2'd1) begin fails++; $display("FAIL wrap_id1_final: got %0d exp 1", rsp_id); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        // Pointer is 2; build a pending result under backpressure.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL mid_pending: got %b exp 1", rsp_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b exp 0", rsp_valid); end
        tests++; if (rsp_sum !== 9'h000) begin fails++; $display("FAIL mid_sum: got %h exp 000", rsp_sum); end
        tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL mid_id: got %0d exp 0", rsp_id); end
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL mid_ready: got %b exp 0000", req_ready); end
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        rst_n     = 1'b1;
        #1;
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL mid_first_grant: got %b exp 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        tests++; if (rsp_id !== 2'd1) begin fails++; $display("FAIL mid_after_id: got %0d exp 1", rsp_id); end
        tests++; if (rsp_sum !== 9'h110) begin fails++; $display("FAIL mid_after_sum: got %h exp 110", rsp_sum); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_random();
        test_round_robin();
        test_backpressure();
        test_pointer_wrap();
        test_reset_mid();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
